timer_prescaler_ctl: RTL and testbench
======================================

// Module: timer_prescaler_ctl
// PURPOSE
// - Configurable event prescaler for the timer/WDT path; successor to the fixed-bit-tap prescaler.
// - Edge-detects a raw source, divides by 2^(sel+1) or bypasses, emits a one-cycle tick.
// - Configuration register is writable and readable; counter clears on config write or clr.
// - Sits between the clock-source mux and TMR0/WDT (OPTION_REG PS/PSA/T0SE).
// PARAMETERS
// - SEL_WIDTH     3          prescaler select width; counter width CNT_W = 2**SEL_WIDTH
// - RESET_SEL     all ones   sel_reg value after reset
// - RESET_BYPASS  1'b1       bypass_reg value after reset (PSA=1)
// - RESET_EDGE    1'b1       edge_reg value after reset (1 = falling, 0 = rising)
// PORTS
// - clk           in   1          clock, all state on posedge
// - rst           in   1          synchronous reset, active-high
// - cfg_wr_en     in   1          load sel/bypass/edge from *_in
// - cfg_sel_in    in   SEL_WIDTH  divide select; ratio N = 2^(sel+1)
// - cfg_bypass_in in   1          1 = tick on every event (no division)
// - cfg_edge_in   in   1          active source edge: 0 rising, 1 falling
// - cfg_sel_out   out  SEL_WIDTH  current sel_reg
// - cfg_bypass_out out 1          current bypass_reg
// - cfg_edge_out  out  1          current edge_reg
// - clr           in   1          clear counter (timer-register write)
// - src_in        in   1          raw event source (level)
// - count_out     out  CNT_W      current counter value
// - tick          out  1          registered one-cycle divided-event pulse
// BEHAVIOUR
// - Reset: counter=0, tick=0, src_prev=0, sync flops=0, sel/bypass/edge = RESET_* params.
// - src_s = src_in (or synchronised copy, see CONFIGURATION); src_prev <= src_s every cycle.
// - event = edge_reg ? (src_prev & ~src_s) : (~src_prev & src_s); uses current edge_reg.
// - Priority per cycle: rst > cfg_wr_en > clr > event.
// - cfg_wr_en: regs load; counter <= 0; tick <= 0; a coincident event is discarded.
// - clr (no cfg write): counter <= 0; tick <= 0; coincident event discarded.
// - Bypass=1 and event: tick <= 1 next edge; counter held.
// - Bypass=0 and event: if counter == N-1 then counter <= 0, tick <= 1; else counter+1, tick <= 0.
// - No event: tick <= 0 (tick never exceeds one cycle; back-to-back ticks only if events back-to-back).
// - Latency: src edge sampled at edge k -> tick high in cycle after edge k (bypass).
// - Arithmetic: N-1 = (1 << (sel+1)) - 1 computed at CNT_W+1 bits; sel=max gives N=2^CNT_W, counter wraps all-ones->0.
// - New config effective the cycle after write; counter never exceeds N-1 for active sel.
// - Edge polarity change does not itself create an event (src_prev tracks raw level).
// - Reset mid-count: counter and tick drop next edge; regs return to RESET_* values.
// CONFIGURATION
// - PRESCALER_SYNC_EN defined: src_in through 2-flop synchroniser (reset 0) before edge detect;
//   +2 cycles src-to-tick latency.
// - Undefined: src_s = src_in directly; src_in must be synchronous to clk.
// TESTING
// - Reset, no stimulus -> count_out=0, tick=0, cfg_sel_out=3'b111, bypass=1, edge=1.
// - Cfg sel=0, bypass=0, edge=0; 4 rising edges -> tick after 2nd and 4th edge; count 1,0,1,0.
// - Sel=7, 256 rising edges -> one tick after 256th; count_out 255 -> 0.
// - Bypass=1, falling-edge mode; 3 falling edges -> 3 one-cycle ticks; rising edges ignored.
// - Sel=2, count=5; clr coincident with edge -> count=0, tick=0; cfg write mid-count -> count=0.
// - PRESCALER_SYNC_EN, bypass: src rises at edge k -> tick high after edge k+2, i.e. 2 cycles later than unsync build.

Source files
------------

// File: rtl/timer_prescaler_ctl.sv
// Configurable event prescaler: edge-detects src_in, divides by 2^(sel+1) or bypasses, emits a one-cycle tick.
// Optional input synchroniser enabled by defining PRESCALER_SYNC_EN.
module timer_prescaler_ctl #(
    parameter int                   SEL_WIDTH    = 3,
    parameter int                   CNT_W        = 2**SEL_WIDTH,
    parameter logic [SEL_WIDTH-1:0] RESET_SEL    = '1,
    parameter logic                 RESET_BYPASS = 1'b1,
    parameter logic                 RESET_EDGE   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_wr_en,
    input  logic [SEL_WIDTH-1:0] cfg_sel_in,
    input  logic                 cfg_bypass_in,
    input  logic                 cfg_edge_in,
    output logic [SEL_WIDTH-1:0] cfg_sel_out,
    output logic                 cfg_bypass_out,
    output logic                 cfg_edge_out,
    input  logic                 clr,
    input  logic                 src_in,
    output logic [CNT_W-1:0]     count_out,
    output logic                 tick
);

    logic [SEL_WIDTH-1:0] sel_q, sel_d;
    logic                 byp_q, byp_d;
    logic                 edge_q, edge_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 tick_q, tick_d;
    logic                 src_prev_q;
    logic                 src_s;
    logic                 evt;
    logic [CNT_W:0]       lim;

`ifdef PRESCALER_SYNC_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= src_in;
            sync2_q <= sync1_q;
        end
    end

    assign src_s = sync2_q;
`else
    assign src_s = src_in;
`endif

    assign evt = edge_q ? (src_prev_q & ~src_s) : (~src_prev_q & src_s);

    // One extra bit so sel=max gives N-1 = all ones without overflow.
    assign lim = ((CNT_W+1)'(1) << ({1'b0, sel_q} + (SEL_WIDTH+1)'(1))) - (CNT_W+1)'(1);

    always_comb begin
        sel_d  = sel_q;
        byp_d  = byp_q;
        edge_d = edge_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (cfg_wr_en) begin
            sel_d  = cfg_sel_in;
            byp_d  = cfg_bypass_in;
            edge_d = cfg_edge_in;
            cnt_d  = '0;
        end else if (clr) begin
            cnt_d = '0;
        end else if (evt) begin
            if (byp_q) begin
                tick_d = 1'b1;
            end else if ({1'b0, cnt_q} == lim) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q      <= RESET_SEL;
            byp_q      <= RESET_BYPASS;
            edge_q     <= RESET_EDGE;
            cnt_q      <= '0;
            tick_q     <= 1'b0;
            src_prev_q <= 1'b0;
        end else begin
            sel_q      <= sel_d;
            byp_q      <= byp_d;
            edge_q     <= edge_d;
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
            src_prev_q <= src_s;
        end
    end

    assign cfg_sel_out    = sel_q;
    assign cfg_bypass_out = byp_q;
    assign cfg_edge_out   = edge_q;
    assign count_out      = cnt_q;
    assign tick           = tick_q;

endmodule

// File: tb/tb_timer_prescaler_ctl.sv
// Directed-vector bench for timer_prescaler_ctl; each task checks one scenario inline.
module tb_timer_prescaler_ctl;

`ifdef PRESCALER_SYNC_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_wr_en;
    logic [2:0] cfg_sel_in;
    logic       cfg_bypass_in;
    logic       cfg_edge_in;
    logic [2:0] cfg_sel_out;
    logic       cfg_bypass_out;
    logic       cfg_edge_out;
    logic       clr;
    logic       src_in;
    logic [7:0] count_out;
    logic       tick;

    int checks = 0;
    int errors = 0;

    timer_prescaler_ctl dut (
        .clk(clk), .rst(rst),
        .cfg_wr_en(cfg_wr_en), .cfg_sel_in(cfg_sel_in),
        .cfg_bypass_in(cfg_bypass_in), .cfg_edge_in(cfg_edge_in),
        .cfg_sel_out(cfg_sel_out), .cfg_bypass_out(cfg_bypass_out),
        .cfg_edge_out(cfg_edge_out),
        .clr(clr), .src_in(src_in),
        .count_out(count_out), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Change src and let it traverse the synchroniser (if present); caller does the sampling edge.
    task automatic drive_src(input logic v);
        src_in = v;
        repeat (EXTRA) step();
    endtask

    task automatic cfg(input logic [2:0] sel, input logic byp, input logic edg);
        cfg_wr_en = 1'b1; cfg_sel_in = sel; cfg_bypass_in = byp; cfg_edge_in = edg;
        step();
        cfg_wr_en = 1'b0;
    endtask

    task automatic rise_fall();
        drive_src(1'b1); step();
        drive_src(1'b0); step();
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_wr_en = 1'b0; cfg_sel_in = 3'd0; cfg_bypass_in = 1'b0;
        cfg_edge_in = 1'b0; clr = 1'b0; src_in = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        checks++; if (count_out !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count_out); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", tick); end
        checks++; if (cfg_sel_out !== 3'b111) begin errors++; $display("FAIL reset_sel got %b want 111", cfg_sel_out); end
        checks++; if (cfg_bypass_out !== 1'b1) begin errors++; $display("FAIL reset_bypass got %b want 1", cfg_bypass_out); end
        checks++; if (cfg_edge_out !== 1'b1) begin errors++; $display("FAIL reset_edge got %b want 1", cfg_edge_out); end
    endtask

    task automatic test_latency();
        int n;
        cfg(3'd0, 1'b1, 1'b0);
        src_in = 1'b1;
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (tick === 1'b1) begin n = i; break; end
        end
        checks++; if (n !== 1 + EXTRA) begin errors++; $display("FAIL bypass_latency got %0d want %0d", n, 1 + EXTRA); end
        step();
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL bypass_tick_width got %b want 0", tick); end
        drive_src(1'b0); step();
    endtask

    task automatic test_div2();
        logic [7:0] exp_c [4] = '{8'd1, 8'd0, 8'd1, 8'd0};
        logic       exp_t [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        cfg(3'd0, 1'b0, 1'b0);
        checks++; if ({cfg_sel_out, cfg_bypass_out, cfg_edge_out} !== 5'b000_0_0) begin
            errors++; $display("FAIL cfg_readback got %b want 00000", {cfg_sel_out, cfg_bypass_out, cfg_edge_out}); end
        for (int i = 0; i < 4; i++) begin
            drive_src(1'b1); step();
            checks++; if (count_out !== exp_c[i] || tick !== exp_t[i]) begin
                errors++; $display("FAIL div2_edge%0d got cnt=%0d tick=%b want cnt=%0d tick=%b", i, count_out, tick, exp_c[i], exp_t[i]); end
            drive_src(1'b0); step();
            checks++; if (tick !== 1'b0) begin errors++; $display("FAIL div2_fall%0d tick got %b want 0", i, tick); end
        end
    endtask

    task automatic test_div256();
        int early = 0;
        cfg(3'd7, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            drive_src(1'b1); step();
            if (i < 255 && tick !== 1'b0) early++;
            if (i == 254) begin
                checks++; if (count_out !== 8'd255) begin errors++; $display("FAIL div256_max got %0d want 255", count_out); end
            end
            if (i == 255) begin
                checks++; if (count_out !== 8'd0 || tick !== 1'b1) begin
                    errors++; $display("FAIL div256_wrap got cnt=%0d tick=%b want cnt=0 tick=1", count_out, tick); end
            end
            drive_src(1'b0); step();
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL div256_early_ticks got %0d want 0", early); end
    endtask

    task automatic test_bypass_fall();
        cfg(3'd0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive_src(1'b1); step();
            checks++; if (tick !== 1'b0) begin errors++; $display("FAIL fall_rise_ignored%0d got %b want 0", i, tick); end
            drive_src(1'b0); step();
            checks++; if (tick !== 1'b1 || count_out !== 8'd0) begin
                errors++; $display("FAIL fall_tick%0d got tick=%b cnt=%0d want tick=1 cnt=0", i, tick, count_out); end
            step();
            checks++; if (tick !== 1'b0) begin errors++; $display("FAIL fall_tick_width%0d got %b want 0", i, tick); end
        end
    endtask

    task automatic test_clr_cfg();
        cfg(3'd2, 1'b0, 1'b0);
        repeat (5) rise_fall();
        checks++; if (count_out !== 8'd5) begin errors++; $display("FAIL sel2_count got %0d want 5", count_out); end
        drive_src(1'b1);
        clr = 1'b1; step(); clr = 1'b0;
        checks++; if (count_out !== 8'd0 || tick !== 1'b0) begin
            errors++; $display("FAIL clr_coincident got cnt=%0d tick=%b want 0/0", count_out, tick); end
        drive_src(1'b0); step();
        repeat (3) rise_fall();
        checks++; if (count_out !== 8'd3) begin errors++; $display("FAIL sel2_recount got %0d want 3", count_out); end
        drive_src(1'b1);
        cfg(3'd2, 1'b0, 1'b0);
        checks++; if (count_out !== 8'd0 || tick !== 1'b0) begin
            errors++; $display("FAIL cfg_coincident got cnt=%0d tick=%b want 0/0", count_out, tick); end
        drive_src(1'b0); step();
        repeat (7) rise_fall();
        checks++; if (count_out !== 8'd7) begin errors++; $display("FAIL sel2_max got %0d want 7", count_out); end
        drive_src(1'b1); step();
        checks++; if (count_out !== 8'd0 || tick !== 1'b1) begin
            errors++; $display("FAIL sel2_wrap got cnt=%0d tick=%b want 0/1", count_out, tick); end
        // src held high while edge polarity flips: no event may appear
        cfg(3'd2, 1'b0, 1'b1);
        repeat (EXTRA + 2) step();
        checks++; if (count_out !== 8'd0 || tick !== 1'b0) begin
            errors++; $display("FAIL polarity_change got cnt=%0d tick=%b want 0/0", count_out, tick); end
        drive_src(1'b0); step();
        checks++; if (count_out !== 8'd1) begin errors++; $display("FAIL polarity_fall_count got %0d want 1", count_out); end
    endtask

    task automatic test_reset_mid();
        rise_fall();
        rise_fall();
        rst = 1'b1; step(); rst = 1'b0;
        checks++; if (count_out !== 8'd0 || tick !== 1'b0) begin
            errors++; $display("FAIL reset_mid got cnt=%0d tick=%b want 0/0", count_out, tick); end
        checks++; if ({cfg_sel_out, cfg_bypass_out, cfg_edge_out} !== 5'b111_1_1) begin
            errors++; $display("FAIL reset_mid_cfg got %b want 11111", {cfg_sel_out, cfg_bypass_out, cfg_edge_out}); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_div2();
        test_div256();
        test_bypass_fall();
        test_clr_cfg();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
